// File: rtl/igmii_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one IGMII transmit link between NUM_SRC frame
//          sources; wraps each frame in preamble + SFD and enforces the inter-packet gap.
// Latency: a beat accepted on clock-enabled beat n appears on o_dv/o_d/o_er at beat n+1;
//          PRE_LEN + 2 enabled beats from request to the first data byte on the link.
// Backpressure: o_rdy is combinational and only asserts for the granted source in DATA on
//          an enabled beat; a missing i_vld is not a stall, it is sent as an error byte.
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_clk_en           IGMII clock enable; every register update is qualified by it
//   i_req/i_vld/i_data/i_last/i_err  per-source frame request and beat stream
//   o_rdy              per-source beat accept (one-hot, granted source only)
//   o_gnt              one-hot current grant, held from arbitration to last beat
//   o_dv/o_d/o_er      registered IGMII transmit signals
//   o_busy             arbiter is inside a frame or its gap (state != IDLE)

module igmii_tx_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DW      = 8,
    parameter int PRE_LEN = 7,
    parameter int IPG_LEN = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clk_en,
    input  logic [NUM_SRC-1:0]    i_req,
    input  logic [NUM_SRC-1:0]    i_vld,
    input  logic [NUM_SRC*DW-1:0] i_data,
    input  logic [NUM_SRC-1:0]    i_last,
    input  logic [NUM_SRC-1:0]    i_err,
    output logic [NUM_SRC-1:0]    o_rdy,
    output logic [NUM_SRC-1:0]    o_gnt,
    output logic                  o_dv,
    output logic [DW-1:0]         o_d,
    output logic                  o_er,
    output logic                  o_busy
);

    // ------------------------------------------------------------------
    // Parameter legality, rejected at elaboration
    // ------------------------------------------------------------------
    generate
        if (DW != 8) begin : g_dw_check
            $fatal(1, "igmii_tx_arbiter: DW must be 8");
        end
        if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_src_check
            $fatal(1, "igmii_tx_arbiter: NUM_SRC must be 2..8");
        end
        if (PRE_LEN < 1 || PRE_LEN > 15) begin : g_pre_check
            $fatal(1, "igmii_tx_arbiter: PRE_LEN must be 1..15");
        end
        if (IPG_LEN < 1 || IPG_LEN > 63) begin : g_ipg_check
            $fatal(1, "igmii_tx_arbiter: IPG_LEN must be 1..63");
        end
    endgenerate

    localparam int         IW       = $clog2(NUM_SRC);
    localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
    localparam logic [5:0] IPG_LAST = 6'(IPG_LEN - 1);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_IPG
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [5:0]      cnt;
    logic [5:0]      cnt_nxt;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   last_gnt;
    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic            dv_nxt;
    logic [DW-1:0]   d_nxt;
    logic            er_nxt;

    // Per-source view of the packed data bus
    logic [DW-1:0]   src_data [NUM_SRC];

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
            assign src_data[k] = i_data[k*DW +: DW];
        end
    endgenerate

    // Signals of the currently granted source
    logic            vld_g;
    logic            last_g;
    logic            err_g;
    logic [DW-1:0]   data_g;
    logic            frame_end;

    assign vld_g     = i_vld[gnt_idx];
    assign last_g    = i_last[gnt_idx];
    assign err_g     = i_err[gnt_idx];
    assign data_g    = src_data[gnt_idx];
    assign frame_end = (state == ST_DATA) && vld_g && last_g;

    // ------------------------------------------------------------------
    // Round-robin search: first requester at or after last_gnt+1 (mod N).
    // last_gnt resets to NUM_SRC-1 so source 0 wins the first arbitration.
    // ------------------------------------------------------------------
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!arb_found && i_req[j] &&
                    (j == (int'(last_gnt) + 1 + i) % NUM_SRC)) begin
                    arb_found = 1'b1;
                    arb_idx   = IW'(j);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (i_clk_en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. cnt counts preamble beats in PRE and idle
    // beats in IPG; it is always zero on entry to either state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    state_nxt = ST_PRE;
                    cnt_nxt   = '0;
                end
            end
            ST_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_nxt = ST_SFD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 6'd1;
                end
            end
            ST_SFD: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (frame_end) begin
                    state_nxt = ST_IPG;
                    cnt_nxt   = '0;
                end
            end
            ST_IPG: begin
                if (cnt == IPG_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 6'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Computes the next link byte for the current
    // state; an underrun in DATA still drives dv so the frame stays
    // delimited, but marks the byte bad with er.
    // ------------------------------------------------------------------
    always_comb begin
        dv_nxt = 1'b0;
        d_nxt  = '0;
        er_nxt = 1'b0;
        case (state)
            ST_PRE: begin
                dv_nxt = 1'b1;
                d_nxt  = PRE_BYTE;
            end
            ST_SFD: begin
                dv_nxt = 1'b1;
                d_nxt  = SFD_BYTE;
            end
            ST_DATA: begin
                dv_nxt = 1'b1;
                if (vld_g) begin
                    d_nxt  = data_g;
                    er_nxt = err_g;
                end else begin
                    er_nxt = 1'b1;
                end
            end
            default: begin
                dv_nxt = 1'b0;
            end
        endcase
    end

    // Registered link outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dv <= 1'b0;
            o_d  <= '0;
            o_er <= 1'b0;
        end else if (i_clk_en) begin
            o_dv <= dv_nxt;
            o_d  <= d_nxt;
            o_er <= er_nxt;
        end
    end

    // Grant bookkeeping: loaded on the arbitration beat, released on the
    // accepted last beat, which also moves the round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_idx  <= '0;
            o_gnt    <= '0;
            last_gnt <= IW'(NUM_SRC - 1);
        end else if (i_clk_en) begin
            if (state == ST_IDLE && arb_found) begin
                gnt_idx <= arb_idx;
                o_gnt   <= NUM_SRC'(1) << arb_idx;
            end else if (frame_end) begin
                o_gnt    <= '0;
                last_gnt <= gnt_idx;
            end
        end
    end

    // o_gnt is one-hot for the whole of DATA, so it doubles as the rdy mask
    assign o_rdy  = o_gnt & {NUM_SRC{i_clk_en & vld_g & (state == ST_DATA)}};
    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_igmii_tx_arbiter.sv
// Directed bench for igmii_tx_arbiter: table of per-beat vectors for whole frames
// (single frame, round-robin, underrun/error, single-beat error frame), plus
// hand-written sequences for clk_en throttling, async reset mid-frame and a
// PRE_LEN=1/IPG_LEN=1 instance.

module tb_igmii_tx_arbiter;

    localparam int PRE_LEN = 7;
    localparam int IPG_LEN = 12;

    logic        clk;
    logic        rst;
    logic        clk_en;

    // default-parameter instance
    logic [1:0]  req, vld, last, err;
    logic [15:0] data;
    logic [1:0]  rdy, gnt;
    logic        dv, er, busy;
    logic [7:0]  d;

    // PRE_LEN=1, IPG_LEN=1 instance
    logic [1:0]  req_b, vld_b, last_b, err_b;
    logic [15:0] data_b;
    logic [1:0]  rdy_b, gnt_b;
    logic        dv_b, er_b, busy_b;
    logic [7:0]  d_b;

    int checks = 0;
    int errors = 0;

    igmii_tx_arbiter #(.NUM_SRC(2), .DW(8), .PRE_LEN(PRE_LEN), .IPG_LEN(IPG_LEN)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
        .i_req(req), .i_vld(vld), .i_data(data), .i_last(last), .i_err(err),
        .o_rdy(rdy), .o_gnt(gnt), .o_dv(dv), .o_d(d), .o_er(er), .o_busy(busy)
    );

    igmii_tx_arbiter #(.NUM_SRC(2), .DW(8), .PRE_LEN(1), .IPG_LEN(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
        .i_req(req_b), .i_vld(vld_b), .i_data(data_b), .i_last(last_b), .i_err(err_b),
        .o_rdy(rdy_b), .o_gnt(gnt_b), .o_dv(dv_b), .o_d(d_b), .o_er(er_b), .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         rep;
        logic [1:0] req, vld, last, err;
        logic [7:0] d0, d1;
        logic [1:0] e_rdy;
        logic       e_dv;
        logic [7:0] e_d;
        logic       e_er;
        logic [1:0] e_gnt;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int rep, input logic [1:0] rq, input logic [1:0] vl,
                           input logic [1:0] ls, input logic [1:0] er_in,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] e_rdy, input logic e_dv, input logic [7:0] e_d,
                           input logic e_er, input logic [1:0] e_gnt, input logic e_busy);
        vec_t v;
        v.rep = rep; v.req = rq; v.vld = vl; v.last = ls; v.err = er_in;
        v.d0 = d0; v.d1 = d1; v.e_rdy = e_rdy; v.e_dv = e_dv; v.e_d = e_d;
        v.e_er = e_er; v.e_gnt = e_gnt; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    // Whole frame from one source: arbitration beat, preamble, SFD, n data
    // bytes (byte i = bytes[8*i +: 8]), then the full gap back to IDLE.
    task automatic add_frame(input logic [1:0] rq, input int src, input int n,
                             input logic [31:0] bytes, input logic lerr);
        logic [1:0] g;
        logic [7:0] b;
        logic [7:0] d0, d1;
        logic [1:0] ls, es;
        g  = (src == 0) ? 2'b01 : 2'b10;
        b  = bytes[7:0];
        d0 = (src == 0) ? b : 8'hEE;
        d1 = (src == 1) ? b : 8'hEE;
        add_vec(1,           rq, 2'b11, 2'b00, 2'b00, d0, d1, 2'b00, 1'b0, 8'h00, 1'b0, g, 1'b1);
        add_vec(PRE_LEN,     rq, 2'b11, 2'b00, 2'b00, d0, d1, 2'b00, 1'b1, 8'h55, 1'b0, g, 1'b1);
        add_vec(1,           rq, 2'b11, 2'b00, 2'b00, d0, d1, 2'b00, 1'b1, 8'hD5, 1'b0, g, 1'b1);
        for (int i = 0; i < n; i++) begin
            b  = bytes[8*i +: 8];
            d0 = (src == 0) ? b : 8'hEE;
            d1 = (src == 1) ? b : 8'hEE;
            ls = (i == n - 1) ? g : 2'b00;
            es = (i == n - 1 && lerr) ? g : 2'b00;
            add_vec(1, rq, 2'b11, ls, es, d0, d1, g, 1'b1, b, (es != 2'b00),
                    (i == n - 1) ? 2'b00 : g, 1'b1);
        end
        add_vec(IPG_LEN - 1, rq, 2'b11, 2'b00, 2'b00, 8'hEE, 8'hEE, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
        add_vec(1,           rq, 2'b11, 2'b00, 2'b00, 8'hEE, 8'hEE, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
    endtask

    // Entered and left at posedge+1
    task automatic run_vectors(input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                clk_en = 1'b1;
                req    = vecs[k].req;
                vld    = vecs[k].vld;
                last   = vecs[k].last;
                err    = vecs[k].err;
                data   = {vecs[k].d1, vecs[k].d0};
                #1;
                check($sformatf("%s v%0d.%0d rdy", tag, k, r), 32'(rdy), 32'(vecs[k].e_rdy));
                @(posedge clk); #1;
                check($sformatf("%s v%0d.%0d dv", tag, k, r),   32'(dv),   32'(vecs[k].e_dv));
                check($sformatf("%s v%0d.%0d d", tag, k, r),    32'(d),    32'(vecs[k].e_d));
                check($sformatf("%s v%0d.%0d er", tag, k, r),   32'(er),   32'(vecs[k].e_er));
                check($sformatf("%s v%0d.%0d gnt", tag, k, r),  32'(gnt),  32'(vecs[k].e_gnt));
                check($sformatf("%s v%0d.%0d busy", tag, k, r), 32'(busy), 32'(vecs[k].e_busy));
            end
        end
        vecs.delete();
    endtask

    // Reset is applied with clk_en low; ends at posedge+1 in IDLE
    task automatic do_reset();
        rst = 1'b1; clk_en = 1'b0;
        req = '0; vld = '0; last = '0; err = '0; data = '0;
        req_b = '0; vld_b = '0; last_b = '0; err_b = '0; data_b = '0;
        @(posedge clk); #1;
        check("rst dv",   32'(dv),   32'd0);
        check("rst d",    32'(d),    32'd0);
        check("rst er",   32'(er),   32'd0);
        check("rst gnt",  32'(gnt),  32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rdy",  32'(rdy),  32'd0);
        check("rst b dv", 32'(dv_b), 32'd0);
        clk_en = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        logic       exp_dv;
        logic [7:0] eb_d [8];
        logic       eb_dv [8];
        int         k;

        // ---------------- single frame, src0, 01..04 ----------------
        do_reset();
        add_frame(2'b01, 0, 4, 32'h04030201, 1'b0);
        add_vec(1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
        run_vectors("single");

        // ---------------- round robin 0,1,0,1 ----------------
        do_reset();
        add_frame(2'b11, 0, 2, 32'h0000A2A1, 1'b0);
        add_frame(2'b11, 1, 2, 32'h0000B2B1, 1'b0);
        add_frame(2'b11, 0, 2, 32'h0000A4A3, 1'b0);
        add_frame(2'b11, 1, 2, 32'h0000B4B3, 1'b0);
        run_vectors("rr");

        // ---------------- underrun + error, then single-beat error frame ----------------
        do_reset();
        add_vec(1,       2'b10, 2'b10, 2'b00, 2'b00, 8'hEE, 8'h11, 2'b00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b1);
        add_vec(PRE_LEN, 2'b10, 2'b10, 2'b00, 2'b00, 8'hEE, 8'h11, 2'b00, 1'b1, 8'h55, 1'b0, 2'b10, 1'b1);
        add_vec(1,       2'b10, 2'b10, 2'b00, 2'b00, 8'hEE, 8'h11, 2'b00, 1'b1, 8'hD5, 1'b0, 2'b10, 1'b1);
        add_vec(1,       2'b10, 2'b10, 2'b00, 2'b00, 8'hEE, 8'h11, 2'b10, 1'b1, 8'h11, 1'b0, 2'b10, 1'b1);
        add_vec(2,       2'b10, 2'b00, 2'b00, 2'b00, 8'hEE, 8'hEE, 2'b00, 1'b1, 8'h00, 1'b1, 2'b10, 1'b1);
        add_vec(1,       2'b10, 2'b10, 2'b00, 2'b10, 8'hEE, 8'hAA, 2'b10, 1'b1, 8'hAA, 1'b1, 2'b10, 1'b1);
        add_vec(1,       2'b10, 2'b10, 2'b10, 2'b00, 8'hEE, 8'h22, 2'b10, 1'b1, 8'h22, 1'b0, 2'b00, 1'b1);
        add_vec(IPG_LEN - 1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
        add_vec(1,       2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0);
        add_frame(2'b01, 0, 1, 32'h0000005A, 1'b1);
        run_vectors("underrun");

        // ---------------- clk_en throttling, 3-byte frame C1..C3 ----------------
        do_reset();
        k = 0;
        for (int b = 0; b < 25; b++) begin
            clk_en = 1'b1;
            req    = (k < 3) ? 2'b01 : 2'b00;
            vld    = 2'b01;
            data   = {8'h00, 8'(8'hC1 + k)};
            last   = (k == 2) ? 2'b01 : 2'b00;
            err    = 2'b00;
            #1;
            check($sformatf("thr b%0d rdy", b), 32'(rdy), (b >= 9 && b <= 11) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            exp_dv = (b >= 1 && b <= 11);
            exp_d  = (b >= 1 && b <= 7) ? 8'h55 :
                     (b == 8)           ? 8'hD5 :
                     (b >= 9 && b <= 11) ? 8'(8'hC1 + (b - 9)) : 8'h00;
            check($sformatf("thr b%0d dv", b),  32'(dv),  32'(exp_dv));
            check($sformatf("thr b%0d d", b),   32'(d),   32'(exp_d));
            check($sformatf("thr b%0d gnt", b), 32'(gnt), (b <= 10) ? 32'd1 : 32'd0);
            if (b >= 9 && b <= 11) k++;
            clk_en = 1'b0;
            #1;
            check($sformatf("thr b%0d off rdy", b), 32'(rdy), 32'd0);
            @(posedge clk); #1;
            check($sformatf("thr b%0d off dv", b),  32'(dv),  32'(exp_dv));
            check($sformatf("thr b%0d off d", b),   32'(d),   32'(exp_d));
            check($sformatf("thr b%0d off er", b),  32'(er),  32'd0);
            check($sformatf("thr b%0d off gnt", b), 32'(gnt), (b <= 10) ? 32'd1 : 32'd0);
        end
        clk_en = 1'b1;

        // ---------------- async reset during SFD ----------------
        do_reset();
        req = 2'b01;
        repeat (PRE_LEN + 1) begin
            @(posedge clk); #1;
        end
        check("mid pre dv",   32'(dv),   32'd1);
        check("mid pre busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid rst dv",   32'(dv),   32'd0);
        check("mid rst d",    32'(d),    32'd0);
        check("mid rst er",   32'(er),   32'd0);
        check("mid rst gnt",  32'(gnt),  32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        req = 2'b10;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mid regrant gnt", 32'(gnt), 32'd2);
        check("mid regrant dv",  32'(dv),  32'd0);
        for (int i = 0; i < PRE_LEN; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid pre%0d d", i), 32'(d), 32'h55);
            check($sformatf("mid pre%0d dv", i), 32'(dv), 32'd1);
        end
        @(posedge clk); #1;
        check("mid sfd d", 32'(d), 32'hD5);
        req = 2'b00;

        // ---------------- PRE_LEN=1, IPG_LEN=1 instance ----------------
        do_reset();
        eb_d  = '{8'h00, 8'h55, 8'hD5, 8'h77, 8'h00, 8'h00, 8'h55, 8'hD5};
        eb_dv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        req_b = 2'b01; vld_b = 2'b01; last_b = 2'b01; data_b = 16'h0077;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("bnd e%0d rdy", i), 32'(rdy_b), (i == 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check($sformatf("bnd e%0d dv", i), 32'(dv_b), 32'(eb_dv[i]));
            check($sformatf("bnd e%0d d", i),  32'(d_b),  32'(eb_d[i]));
            check($sformatf("bnd e%0d er", i), 32'(er_b), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/igmii_tx_arbiter.md
Name: igmii_tx_arbiter

Overview:
- Shares one IGMII transmit link between NUM_SRC frame sources using round-robin arbitration.
- Per frame, it emits the preamble and SFD, streams the granted source's bytes, propagates errors, and enforces the inter-packet gap.
- Sits between the MAC-side frame generators and the igmii interface (clk_en/dv/d/er) signals.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- DW, 8, IGMII data width. Only 8 is legal; any other value is an elaboration error.
- PRE_LEN, 7, number of preamble bytes (0x55) before the SFD (1..15).
- IPG_LEN, 12, idle beats enforced after each frame (1..63).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_clk_en  in  1  IGMII clock enable; all state and output updates are qualified by it.
- i_req  in  NUM_SRC  per-source frame request; held until the frame's last beat is accepted.
- i_vld  in  NUM_SRC  per-source data beat valid.
- i_data  in  NUM_SRC*DW  packed source data; source k occupies bits [k*DW +: DW].
- i_last  in  NUM_SRC  last beat of frame.
- i_err  in  NUM_SRC  beat carries an error.
- o_rdy  out  NUM_SRC  beat accepted; combinational.
- o_gnt  out  NUM_SRC  one-hot current grant.
- o_dv  out  1  IGMII data valid.
- o_d  out  DW  IGMII data.
- o_er  out  1  IGMII error.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: asserting i_rst clears everything immediately, independent of i_clk_en.
  - state=IDLE; o_gnt, o_dv, o_d, o_er, o_busy all 0.
  - RR pointer set so that source 0 has highest priority.
- i_clk_en=0 cycle: no register changes. o_dv/o_d/o_er/o_gnt hold their values; o_rdy=0.
- All transitions below occur only on i_clk=rising with i_clk_en=1. "Beat" means such a cycle.
- o_dv/o_d/o_er are registered: a beat accepted on beat n appears on the outputs at beat n+1.
- IDLE:
  - Outputs dv=0, er=0, d=0.
  - If i_req is nonzero, grant the first requesting source searching from (last_gnt+1) mod NUM_SRC, load o_gnt, and go to PRE.
  - If i_req is zero, stay in IDLE.
- PRE:
  - Emit dv=1, d=0x55 for PRE_LEN beats; the counter starts at 0.
  - Then go to SFD.
- SFD:
  - Emit dv=1, d=0xD5 for one beat.
  - Then go to DATA.
- DATA:
  - o_rdy[g] = i_clk_en & i_vld[g] & (state==DATA), where g is the granted source; all other o_rdy bits are 0.
  - Accepted beat: emit dv=1, d=i_data[g], er=i_err[g].
  - If i_last[g] is set on the accepted beat, go to IPG, clear o_gnt, and set last_gnt=g.
  - Underrun (i_vld[g]=0 on a beat): emit dv=1, er=1, d=0x00 and stay in DATA. The frame is corrupted but still delimited.
- IPG:
  - Emit dv=0, er=0, d=0 for IPG_LEN beats.
  - Then go to IDLE. The IDLE arbitration beat counts as one additional idle beat.
- i_req changes in non-IDLE states are ignored. Requests from non-granted sources wait.
- Simultaneous requests in IDLE: resolved by RR order only.
- A source dropping i_req mid-frame has no effect; the frame ends only on an accepted i_last.
- i_last asserted together with i_err: er=1 on that beat, then normal IPG.
- Single-beat frame (last on the first DATA beat): legal. Sequence is PRE, SFD, 1 data beat, IPG.
- Reset asserted mid-frame: outputs drop to 0 immediately. No trailing er is generated.

Test Plan:
- Single frame: src0 sends 4 bytes 0x01..0x04 with clk_en=1.
  - o_dv high for exactly 12 beats: 7×0x55, 0xD5, 01, 02, 03, 04.
  - er=0 throughout.
  - dv then low for ≥13 beats before the next frame.
- Round-robin: src0 and src1 request together from reset, each with 2-byte frames, requests held continuously.
  - Grant order is 0, 1, 0, 1.
  - Each frame is separated by IPG_LEN+1 idle beats.
- clk_en throttling: clk_en toggles 1,0,1,0 during a 3-byte frame.
  - Output sequence is identical to the clk_en=1 case, at half rate.
  - Outputs are stable on clk_en=0 cycles; o_rdy=0 on those cycles.
- Underrun and error: src1 i_vld drops for 2 beats mid-frame; a later beat 0xAA carries i_err=1.
  - Two beats of dv=1, er=1, d=0x00.
  - Then 0xAA with er=1; the frame continues until last.
- Reset mid-operation: assert i_rst during SFD, asynchronously between clock edges.
  - o_dv, o_gnt, o_busy go to 0 before the next edge.
  - After release, src1 requesting alone is granted and a full preamble restarts.
- Boundary parameters: with PRE_LEN=1 and IPG_LEN=1, a 1-byte frame produces dv pattern 55, D5, xx, followed by 2 idle beats.
